register_fifo: RTL and testbench

Parametrised first-in first-out buffer built from enable-gated register storage; the successor to the fixed 8-bit enable register. It generalises width and depth, adds a val/rdy handshake on both sides, an occupancy count and a synchronous flush. It sits between any producer/consumer pair in the datapath that need decoupling by up to DEPTH messages.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/register_nb.sv | 21 ++
 rtl/register_fifo.sv | 115 +++++++++++
 tb/tb_register_fifo.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing and pointer helpers for the register-based FIFO.
// Pointer and count widths are derived here so every file agrees on them.
package fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps with an explicit compare so non-power-of-two depths stay in range.
  function automatic int unsigned incr_wrap(input int unsigned ptr,
                                            input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/register_nb.sv
// NBITS-wide enable register with asynchronous active-high reset.
// Used for every storage entry, both pointers and the occupancy count.
module register_nb #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NBITS-1:0] d,
  output logic [NBITS-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_fifo.sv
// Parametrised FIFO with val/rdy handshakes, occupancy count and synchronous flush.
// All outputs come from registered state; no input-to-output paths exist.
module register_fifo
  import fifo_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       enq_val,
  output logic                       enq_rdy,
  input  logic [NBITS-1:0]           enq_msg,
  output logic                       deq_val,
  input  logic                       deq_rdy,
  output logic [NBITS-1:0]           deq_msg,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NBITS-1:0] entry_q [DEPTH];

  logic enq_fire, deq_fire;
  logic wr_ptr_en, rd_ptr_en, count_en;

  assign enq_rdy = (count_q != CW'(DEPTH));
  assign deq_val = (count_q != '0);
  assign count   = count_q;

  // clear wins over both handshakes, so neither side may fire under it.
  assign enq_fire = enq_val && enq_rdy && !clear;
  assign deq_fire = deq_val && deq_rdy && !clear;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_ptr_en = 1'b0;
    rd_ptr_en = 1'b0;
    count_en  = 1'b0;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      wr_ptr_en = 1'b1;
      rd_ptr_en = 1'b1;
      count_en  = 1'b1;
    end else begin
      if (enq_fire) begin
        wr_ptr_d  = PW'(incr_wrap(int'(wr_ptr_q), DEPTH));
        wr_ptr_en = 1'b1;
      end
      if (deq_fire) begin
        rd_ptr_d  = PW'(incr_wrap(int'(rd_ptr_q), DEPTH));
        rd_ptr_en = 1'b1;
      end
      if (enq_fire && !deq_fire) begin
        count_d  = count_q + CW'(1);
        count_en = 1'b1;
      end else if (deq_fire && !enq_fire) begin
        count_d  = count_q - CW'(1);
        count_en = 1'b1;
      end
    end
  end

  register_nb #(.NBITS(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (wr_ptr_en),
    .d   (wr_ptr_d),
    .q   (wr_ptr_q)
  );

  register_nb #(.NBITS(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (rd_ptr_en),
    .d   (rd_ptr_d),
    .q   (rd_ptr_q)
  );

  register_nb #(.NBITS(CW)) u_count (
    .clk (clk),
    .rst (rst),
    .en  (count_en),
    .d   (count_d),
    .q   (count_q)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    register_nb #(.NBITS(NBITS)) u_entry (
      .clk (clk),
      .rst (rst),
      .en  (enq_fire && (wr_ptr_q == PW'(i))),
      .d   (enq_msg),
      .q   (entry_q[i])
    );
  end

  // Read mux is a compare chain so pointer codes >= DEPTH never index out of range.
  always_comb begin
    deq_msg = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_ptr_q == PW'(k)) deq_msg = entry_q[k];
    end
  end

endmodule

// File: tb/tb_register_fifo.sv
// Directed bench for register_fifo (NBITS=8, DEPTH=4) with a queue scoreboard
// and an independent occupancy model.
module tb_register_fifo;

  localparam int NBITS = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             enq_val;
  logic             enq_rdy;
  logic [NBITS-1:0] enq_msg;
  logic             deq_val;
  logic             deq_rdy;
  logic [NBITS-1:0] deq_msg;
  logic [2:0]       count;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  logic [NBITS-1:0] sb [$];

  register_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .enq_val (enq_val),
    .enq_rdy (enq_rdy),
    .enq_msg (enq_msg),
    .deq_val (deq_val),
    .deq_rdy (deq_rdy),
    .deq_msg (deq_msg),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(model_cnt));
    chk({tag, ".deq_val"}, 32'(deq_val), 32'(model_cnt != 0));
    chk({tag, ".enq_rdy"}, 32'(enq_rdy), 32'(model_cnt != DEPTH));
  endtask

  // One clock: drive inputs, score any deq against the queue, step, check state.
  task automatic cycle(input string tag, input logic ev, input logic [NBITS-1:0] msg,
                       input logic dr, input logic clr);
    logic [NBITS-1:0] exp_msg;
    logic enq_f, deq_f;
    enq_val = ev;
    enq_msg = msg;
    deq_rdy = dr;
    clear   = clr;
    enq_f = ev && (model_cnt != DEPTH) && !clr;
    deq_f = dr && (model_cnt != 0) && !clr;
    if (deq_f) begin
      exp_msg = sb.pop_front();
      chk({tag, ".deq_msg"}, 32'(deq_msg), 32'(exp_msg));
    end
    if (enq_f) sb.push_back(msg);
    if (clr) sb.delete();
    if (clr) model_cnt = 0;
    else if (enq_f && !deq_f) model_cnt++;
    else if (deq_f && !enq_f) model_cnt--;
    @(posedge clk);
    #1;
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    clear   = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst     = 1'b1;
    clear   = 1'b0;
    enq_val = 1'b0;
    enq_msg = '0;
    deq_rdy = 1'b0;
    #12;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.enq_rdy", 32'(enq_rdy), 32'd1);
    chk("reset.deq_val", 32'(deq_val), 32'd0);
    chk("reset.deq_msg", 32'(deq_msg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic
    cycle("basic.enq", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("basic.deq", 1'b0, 8'h00, 1'b1, 1'b0);

    // fill / full / refused fifth
    for (int i = 1; i <= 4; i++) cycle("fill.enq", 1'b1, 8'(i), 1'b0, 1'b0);
    cycle("full.refuse", 1'b1, 8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("fill.drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fill.sb_empty", 32'(sb.size()), 32'd0);

    // simultaneous enq+deq at count 2, pointers wrap twice
    cycle("simul.pre0", 1'b1, 8'h90, 1'b0, 1'b0);
    cycle("simul.pre1", 1'b1, 8'h91, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle("simul.both", 1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
    cycle("simul.drain0", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("simul.drain1", 1'b0, 8'h00, 1'b1, 1'b0);

    // boundaries: empty deq ignored, full enq ignored
    cycle("bound.empty", 1'b1, 8'h42, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("bound.fill", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    cycle("bound.full", 1'b1, 8'h77, 1'b1, 1'b0);

    // flush with count 3, enq and deq also requested
    cycle("flush.clear", 1'b1, 8'h99, 1'b1, 1'b1);
    cycle("flush.enq", 1'b1, 8'h55, 1'b0, 1'b0);
    cycle("flush.deq", 1'b0, 8'h00, 1'b1, 1'b0);

    // async reset mid-cycle with count 2
    cycle("areset.enq0", 1'b1, 8'hC1, 1'b0, 1'b0);
    cycle("areset.enq1", 1'b1, 8'hC2, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    sb.delete();
    model_cnt = 0;
    #1;
    chk("areset.count", 32'(count), 32'd0);
    chk("areset.deq_val", 32'(deq_val), 32'd0);
    chk("areset.deq_msg", 32'(deq_msg), 32'd0);
    enq_val = 1'b1;
    enq_msg = 8'hEE;
    @(posedge clk);
    #1;
    enq_val = 1'b0;
    chk("areset.hold_count", 32'(count), 32'd0);
    chk("areset.hold_deq_val", 32'(deq_val), 32'd0);
    chk("areset.hold_deq_msg", 32'(deq_msg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle("release.enq", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("release.deq", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
